// File: rtl/cla_adder_pipe_pkg.sv
// Shared constants for the two-stage carry-lookahead adder/subtractor
// and its 4-bit lookahead group.
package cla_adder_pipe_pkg;

  localparam int GROUP_BITS = 4;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: local sums, group propagate/generate and the
// carry into its top bit. P uses A|B, which is valid for carry computation.
module cla_group4
  import cla_adder_pipe_pkg::*;
(
  input  logic [GROUP_BITS-1:0] A,
  input  logic [GROUP_BITS-1:0] B,
  input  logic                  CIN,
  output logic [GROUP_BITS-1:0] S,
  output logic                  PG,
  output logic                  GG,
  output logic                  C3
);

  logic [GROUP_BITS-1:0] p_s;
  logic [GROUP_BITS-1:0] g_s;
  logic [GROUP_BITS-1:0] c_s;

  // Two-level lookahead inside the group.
  always_comb begin
    p_s    = A | B;
    g_s    = A & B;
    c_s[0] = CIN;
    c_s[1] = g_s[0] | (p_s[0] & CIN);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & CIN);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & CIN);
    S      = A ^ B ^ c_s;
    PG     = &p_s;
    GG     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    C3     = c_s[3];
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both
// sides. Define CLA_FLAGS_EN to register the {V, N, Z} flags alongside the sum.
module cla_adder_pipe
  import cla_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic [2:0]       FLAGS
);

  localparam int NGROUP = WIDTH / GROUP_BITS;

  logic              adv1_s;
  logic              adv2_s;
  logic              cin_s;
  logic [WIDTH-1:0]  bb_s;
  logic [NGROUP-1:0] pg_s;
  logic [NGROUP-1:0] gg_s;
  logic [NGROUP:0]   c_s;
  logic [WIDTH-1:0]  s1_sum_s;
  logic [NGROUP-1:0] s1_c3_s;

  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  bb_q, bb_d;
  logic [NGROUP:0]   c_q, c_d;

  logic [WIDTH-1:0]  sum_s;
  logic [NGROUP-1:0] s2_pg_s;
  logic [NGROUP-1:0] s2_gg_s;
  logic [NGROUP-1:0] s2_c3_s;

  logic              s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              unused_s;

  assign adv2_s    = !s2_valid_q || OUT_READY;
  assign adv1_s    = !s1_valid_q || adv2_s;
  assign IN_READY  = adv1_s;
  assign OUT_VALID = s2_valid_q;
  assign S         = s_q;
  assign COUT      = cout_q;

  // Subtraction is A + ~B + 1.
  always_comb begin
    cin_s = (SUB == OP_SUB);
    bb_s  = B ^ {WIDTH{cin_s}};
  end

  // Stage-1 groups only contribute PG/GG, so their carry-in is irrelevant.
  for (genvar k = 0; k < NGROUP; k++) begin : g_s1
    cla_group4 u_grp (
      .A   (A[GROUP_BITS*k +: GROUP_BITS]),
      .B   (bb_s[GROUP_BITS*k +: GROUP_BITS]),
      .CIN (1'b0),
      .S   (s1_sum_s[GROUP_BITS*k +: GROUP_BITS]),
      .PG  (pg_s[k]),
      .GG  (gg_s[k]),
      .C3  (s1_c3_s[k])
    );
  end

  // Group carries as flat sum-of-products, no ripple between groups.
  always_comb begin
    logic term_s;
    c_s    = '0;
    c_s[0] = cin_s;
    for (int k = 0; k < NGROUP; k++) begin
      term_s = cin_s;
      for (int j = 0; j <= k; j++) begin
        term_s = term_s & pg_s[j];
      end
      c_s[k+1] = term_s;
      for (int j = 0; j <= k; j++) begin
        term_s = gg_s[j];
        for (int m = j + 1; m <= k; m++) begin
          term_s = term_s & pg_s[m];
        end
        c_s[k+1] = c_s[k+1] | term_s;
      end
    end
  end

  // Stage-1 next state: load on input transfer, bubble when advancing empty.
  always_comb begin
    if (adv1_s) begin
      s1_valid_d = IN_VALID;
      if (IN_VALID) begin
        a_d  = A;
        bb_d = bb_s;
        c_d  = c_s;
      end else begin
        a_d  = a_q;
        bb_d = bb_q;
        c_d  = c_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
      a_d        = a_q;
      bb_d       = bb_q;
      c_d        = c_q;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      bb_q       <= '0;
      c_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      bb_q       <= bb_d;
      c_q        <= c_d;
    end
  end

  for (genvar k = 0; k < NGROUP; k++) begin : g_s2
    cla_group4 u_grp (
      .A   (a_q[GROUP_BITS*k +: GROUP_BITS]),
      .B   (bb_q[GROUP_BITS*k +: GROUP_BITS]),
      .CIN (c_q[k]),
      .S   (sum_s[GROUP_BITS*k +: GROUP_BITS]),
      .PG  (s2_pg_s[k]),
      .GG  (s2_gg_s[k]),
      .C3  (s2_c3_s[k])
    );
  end

  // Stage-2 next state: outputs only change when a result moves in.
  always_comb begin
    if (adv2_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s_d    = sum_s;
        cout_d = c_q[NGROUP];
      end else begin
        s_d    = s_q;
        cout_d = cout_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
      s_d        = s_q;
      cout_d     = cout_q;
    end
  end

  // Stage-2 registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s2_valid_q <= 1'b0;
      s_q        <= '0;
      cout_q     <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s_q        <= s_d;
      cout_q     <= cout_d;
    end
  end

`ifdef CLA_FLAGS_EN
  logic [2:0] flags_calc_s;
  logic [2:0] flags_q, flags_d;

  // Overflow is the carry into the MSB differing from the carry out of it.
  always_comb begin
    flags_calc_s         = 3'b000;
    flags_calc_s[FLAG_V] = s2_c3_s[NGROUP-1] ^ c_q[NGROUP];
    flags_calc_s[FLAG_N] = sum_s[WIDTH-1];
    flags_calc_s[FLAG_Z] = ~|sum_s;
  end

  // Flags follow the same load/hold rule as the sum.
  always_comb begin
    if (adv2_s && s1_valid_q) begin
      flags_d = flags_calc_s;
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign FLAGS = flags_q;
`else
  assign FLAGS = 3'b000;
`endif

  assign unused_s = ^{s1_sum_s, s1_c3_s, s2_pg_s, s2_gg_s, s2_c3_s};

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed self-checking bench for cla_adder_pipe: hand-computed vectors,
// backpressure stream, mid-flight reset and a randomized scoreboard run.
module tb_cla_adder_pipe;
  import cla_adder_pipe_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         SUB;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] S;
  logic         COUT;
  logic [2:0]   FLAGS;

  int n_checks = 0;
  int n_pass   = 0;
  int n_in     = 0;
  int n_out    = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic [2:0]  f;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  logic [35:0] exp_q[$];
  logic        hold_pending = 1'b0;
  logic [31:0] held_s;
  logic        held_c;
  logic [2:0]  held_f;
  logic        last_in_fire;
  logic        rdy_sample;

  always #5 CLK = ~CLK;

  cla_adder_pipe #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .S         (S),
    .COUT      (COUT),
    .FLAGS     (FLAGS)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] flags_exp(input logic [2:0] f);
`ifdef CLA_FLAGS_EN
    return f;
`else
    return 3'b000;
`endif
  endfunction

  // Reference: {flags, cout, sum} from plain wide arithmetic.
  function automatic logic [35:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] r;
    logic [31:0] bo;
    logic        v;
    bo = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bo} + {32'd0, sub};
    v  = (a[31] == bo[31]) && (r[31] != a[31]);
    return {flags_exp({v, r[31], (r[31:0] == 32'd0)}), r[32], r[31:0]};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    A = v.a; B = v.b; SUB = v.sub; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1;
    check({tag, "_in_ready"}, IN_READY, 1'b1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    check({tag, "_lat1_valid"}, OUT_VALID, 1'b0);
    @(posedge CLK); #1;
    check({tag, "_lat2_valid"}, OUT_VALID, 1'b1);
    check({tag, "_s"}, S, v.s);
    check({tag, "_cout"}, COUT, v.c);
    check({tag, "_flags"}, FLAGS, flags_exp(v.f));
    @(posedge CLK); #1;
    check({tag, "_drained"}, OUT_VALID, 1'b0);
  endtask

  // One cycle with scoreboard and stall-stability checking; call just after driving.
  task automatic tick();
    logic        in_fire;
    logic        out_fire;
    logic [35:0] e;
    #1;
    in_fire    = IN_VALID && IN_READY;
    out_fire   = OUT_VALID && OUT_READY;
    rdy_sample = IN_READY;
    if (hold_pending) begin
      check("stall_valid", OUT_VALID, 1'b1);
      check("stall_s", S, held_s);
      check("stall_cout", COUT, held_c);
      check("stall_flags", FLAGS, held_f);
      hold_pending = 1'b0;
    end
    if (out_fire) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("extra_result", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("res_s", S, e[31:0]);
        check("res_cout", COUT, e[32]);
        check("res_flags", FLAGS, e[35:33]);
      end
    end
    if (OUT_VALID && !OUT_READY) begin
      hold_pending = 1'b1;
      held_s = S; held_c = COUT; held_f = FLAGS;
    end
    if (in_fire) begin
      exp_q.push_back(ref_op(A, B, SUB));
      n_in++;
    end
    last_in_fire = in_fire;
    @(posedge CLK); #1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    logic saw_low;

    vecs[0] = '{32'h7FFFFFFF, 32'h00000001, OP_ADD, 32'h80000000, 1'b0, 3'b110};
    vecs[1] = '{32'h00000005, 32'h00000005, OP_SUB, 32'h00000000, 1'b1, 3'b001};
    vecs[2] = '{32'h00000003, 32'h00000005, OP_SUB, 32'hFFFFFFFE, 1'b0, 3'b010};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000001, OP_ADD, 32'h00000000, 1'b1, 3'b001};
    vecs[4] = '{32'h0000FFFF, 32'h00000001, OP_ADD, 32'h00010000, 1'b0, 3'b000};
    vecs[5] = '{32'h80000000, 32'h00000001, OP_SUB, 32'h7FFFFFFF, 1'b1, 3'b100};
    vecs[6] = '{32'h12345678, 32'h9ABCDEF0, OP_ADD, 32'hACF13568, 1'b0, 3'b010};

    RESET = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; SUB = 1'b0; OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", OUT_VALID, 1'b0);
    check("rst_s", S, 32'd0);
    check("rst_cout", COUT, 1'b0);
    check("rst_flags", FLAGS, 3'b000);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("rst_in_ready", IN_READY, 1'b1);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back stream with OUT_READY low for cycles 3-5.
    idx = 0; saw_low = 1'b0; n_out = 0; exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      OUT_READY = !(c >= 3 && c <= 5);
      if (idx < 4) begin
        IN_VALID = 1'b1; A = vecs[idx].a; B = vecs[idx].b; SUB = vecs[idx].sub;
      end else begin
        IN_VALID = 1'b0;
      end
      tick();
      if (!rdy_sample) saw_low = 1'b1;
      if (last_in_fire) idx++;
    end
    check("stream_in_ready_drop", saw_low, 1'b1);
    check("stream_accepted", idx, 4);
    check("stream_results", n_out, 4);
    check("stream_queue_empty", exp_q.size(), 0);

    // Reset with two operations in flight.
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    A = vecs[0].a; B = vecs[0].b; SUB = vecs[0].sub;
    @(posedge CLK); #1;
    A = vecs[1].a; B = vecs[1].b; SUB = vecs[1].sub;
    @(posedge CLK); #1;
    check("mid_inflight_valid", OUT_VALID, 1'b1);
    check("mid_inflight_ready", IN_READY, 1'b0);
    RESET = 1'b1; OUT_READY = 1'b1;
    A = vecs[2].a; B = vecs[2].b; SUB = vecs[2].sub;
    @(posedge CLK); #1;
    RESET = 1'b0; IN_VALID = 1'b0;
    check("mid_rst_out_valid", OUT_VALID, 1'b0);
    check("mid_rst_s", S, 32'd0);
    check("mid_rst_cout", COUT, 1'b0);
    check("mid_rst_flags", FLAGS, 3'b000);
    check("mid_rst_in_ready", IN_READY, 1'b1);
    @(posedge CLK); #1;
    check("mid_rst_no_ghost", OUT_VALID, 1'b0);
    run_vec(vecs[6], "post_rst");

    // Randomized traffic against the reference model.
    n_in = 0; n_out = 0; exp_q.delete(); cyc = 0;
    while (n_in < 10000 && cyc < 60000) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 1) != 0);
      A   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
      B   = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom();
      SUB = $urandom_range(0, 1) != 0;
      tick();
      cyc++;
    end
    check("rand_within_budget", (n_in >= 10000), 1'b1);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() != 0 || hold_pending) tick();
    end
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_result_count", n_out, n_in);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Two-stage pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Consumes per-bit propagate/generate terms in the same form as the 1-bit partial full adder: P = A|B, G = A&B, S = A^B^CIN.
- Produces group carries, then final sums and flags.
- Has valid/ready handshakes on both sides, so it can sit between operand fetch and writeback with backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4.
- NGROUP, WIDTH/4, number of 4-bit lookahead groups (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- IN_VALID  input  1  operands present
- IN_READY  output  1  block can accept operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- SUB  input  1  0: A+B; 1: A-B, computed as A + ~B + 1
- OUT_VALID  output  1  result present
- OUT_READY  input  1  consumer accepts result
- S  output  WIDTH  sum/difference
- COUT  output  1  carry out of the MSB; for SUB, 1 means no borrow
- FLAGS  output  3  {V, N, Z}; present only with CLA_FLAGS_EN

Behaviour:
- Transfers: an input transfer occurs when IN_VALID & IN_READY; an output transfer occurs when OUT_VALID & OUT_READY.
- Stage 1 (on input transfer):
  - Bb = B ^ {WIDTH{SUB}}; CIN0 = SUB.
  - Per-bit P, G.
  - Group terms: PG = &P[4k+3:4k]; GG = G3 | P3G2 | P3P2G1 | P3P2P1G0.
  - Group carry-ins C[k+1] = GG[k] | PG[k]&C[k], with C[0] = CIN0, flattened (no ripple between groups in the RTL description).
  - Registers A, Bb, C[NGROUP-1:0], C[NGROUP], and s1_valid.
- Stage 2: per-group 4-bit lookahead from the registered C[k] gives the sum bits. Registers S, COUT (= C[NGROUP]) and flags; sets s2_valid. OUT_VALID = s2_valid.
- Latency: exactly 2 cycles from input transfer to OUT_VALID when there is no backpressure. Throughput is 1 result/cycle.
- Advance rules:
  - adv2 = !s2_valid | OUT_READY.
  - adv1 = !s1_valid | adv2.
  - IN_READY = adv1 (combinational from OUT_READY; no combinational path from IN_VALID).
- Stall: while OUT_VALID & !OUT_READY, the outputs S, COUT and FLAGS hold bit-stable. Stage 1 holds if it is full. At most 2 transactions are in flight. Results are delivered in order, with no drop or duplicate.
- Bubble: if adv1 and no input transfer, s1_valid clears. If adv2 and !s1_valid, s2_valid clears.
- Arithmetic is modulo 2^WIDTH. There are no X outputs for any defined input.
- Reset (synchronous, also mid-operation): s1_valid = s2_valid = 0, all data registers = 0, S = 0, COUT = 0, FLAGS = 0. IN_READY is 1 in the cycle after reset deasserts. In-flight operations are discarded.
- RESET has priority over every transfer in the same cycle.

Optional Feature:
- Macro: CLA_FLAGS_EN.
- Defined: FLAGS is registered in stage 2 with the same stall/hold rules as S.
  - V = carry into MSB ^ COUT.
  - N = S[WIDTH-1].
  - Z = ~|S.
- Undefined: FLAGS port tied to 3'b000, no flag logic.

Decomposition:
- Shared package:
  - Constant GROUP_BITS = 4.
  - Flag bit indices FLAG_V = 2, FLAG_N = 1, FLAG_Z = 0.
  - Opcode localparams OP_ADD = 0, OP_SUB = 1.
- Sub-module cla_group4: 4-bit lookahead group.
  - Inputs A[3:0], B[3:0], CIN.
  - Outputs S[3:0], PG, GG, C3 (carry into bit 3).
  - Instantiated NGROUP times. Stage 1 uses its PG/GG; stage 2 uses its S.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, OUT_READY = 1 -> OUT_VALID 2 cycles later, S = 0x80000000, COUT = 0, FLAGS = {V1, N1, Z0}.
- SUB 5 - 5 -> S = 0x00000000, COUT = 1, Z = 1, V = 0. SUB 3 - 5 -> S = 0xFFFFFFFE, COUT = 0, N = 1.
- ADD 0xFFFFFFFF + 1 -> S = 0, COUT = 1, Z = 1. ADD 0x0000FFFF + 1 -> S = 0x00010000, exercising carry across 4 group boundaries.
- Stream 4 ops back-to-back with OUT_READY low for cycles 3-5:
  - IN_READY drops after 2 ops are held.
  - S is stable while stalled.
  - All 4 results emerge in order, none lost or duplicated.
- Assert RESET for 1 cycle with 2 ops in flight -> next cycle OUT_VALID = 0, S = 0, IN_READY = 1. A subsequent op completes normally.
- Random 10,000 ops (random SUB, random OUT_READY) checked against a reference A ± B model -> 0 errors reported.
